// File: rtl/fp_mul_result_queue_pkg.sv
// Shared floating-point definitions for the multiplier and its result queue.
// Exception flag bit positions follow the fflags ordering
// {invalid, infinite, overflow, underflow, inexact}.
package fp_mul_result_queue_pkg;

   localparam int unsigned FLAG_W         = 5;
   localparam int unsigned FLAG_INVALID   = 4;
   localparam int unsigned FLAG_INFINITE  = 3;
   localparam int unsigned FLAG_OVERFLOW  = 2;
   localparam int unsigned FLAG_UNDERFLOW = 1;
   localparam int unsigned FLAG_INEXACT   = 0;

   // Fixed val-to-done latency of the pipelined multiplier.
   localparam int unsigned MUL_LATENCY = 4;

   typedef logic [FLAG_W-1:0] fflags_t;

   // Assemble a flag vector from individual exception bits.
   function automatic fflags_t pack_flags(input logic invalid, input logic infinite,
                                          input logic overflow, input logic underflow,
                                          input logic inexact);
      fflags_t f;
      f                 = '0;
      f[FLAG_INVALID]   = invalid;
      f[FLAG_INFINITE]  = infinite;
      f[FLAG_OVERFLOW]  = overflow;
      f[FLAG_UNDERFLOW] = underflow;
      f[FLAG_INEXACT]   = inexact;
      return f;
   endfunction

endpackage

// File: rtl/fp_mul_result_queue_fifo.sv
// fp_sync_fifo: parameterised circular FIFO with occupancy tracking.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   wr_en, wr_data  write request; ignored while full
//   rd_en           read request; ignored while empty
//   rd_data         head entry (zero when empty)
//   full, empty     occupancy == DEPTH / occupancy == 0
//   occ             number of stored entries
module fp_sync_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occ
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // A write while full is dropped even if a read happens in the same cycle.
   assign full  = (occ == OCC_W'(DEPTH));
   assign empty = (occ == '0);
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         occ <= occ + OCC_W'(do_wr) - OCC_W'(do_rd);
      end
   end

   // Storage array; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fp_mul_result_queue.sv
// Result queue behind the fixed-latency FP multiplier: credit-based issue
// control, a result FIFO with ready/valid output, and sticky exception flags.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   issue_val / issue_rdy   upstream issue handshake (rdy = credit available)
//   mul_done, mul_out,      multiplier result strobe, value and flags
//   mul_flags
//   out_valid / out_ready   consumer handshake for the head result
//   out_data, out_flags     head result value and flags
//   sticky_flags            OR of flags of all stored results since clear
//   clear_flags             clears sticky_flags
//   overflow_err            sticky: a result arrived while the FIFO was full
module fp_mul_result_queue
   import fp_mul_result_queue_pkg::*;
#(
   parameter int unsigned expWidth = 8,
   parameter int unsigned sigWidth = 24,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned LATENCY  = MUL_LATENCY
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         issue_val,
   output logic                         issue_rdy,
   input  logic                         mul_done,
   input  logic [expWidth+sigWidth-1:0] mul_out,
   input  logic [FLAG_W-1:0]            mul_flags,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [expWidth+sigWidth-1:0] out_data,
   output logic [FLAG_W-1:0]            out_flags,
   output logic [FLAG_W-1:0]            sticky_flags,
   input  logic                         clear_flags,
   output logic                         overflow_err
);

   localparam int unsigned DATA_W  = expWidth + sigWidth;
   localparam int unsigned ENTRY_W = DATA_W + FLAG_W;
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam bit DEPTH_OK = (DEPTH >= LATENCY + 2) && ((DEPTH & (DEPTH - 1)) == 0);

   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   fifo_occ;
   logic [ENTRY_W-1:0] head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fire;
   logic               pop;
   logic               push_ok;
   fflags_t            sticky_q;
   logic               overflow_q;

   // Every output is forced low while reset is held.
   assign issue_rdy    = ~reset & (count < CNT_W'(DEPTH));
   assign out_valid    = ~reset & ~fifo_empty;
   assign out_data     = reset ? '0 : head[ENTRY_W-1:FLAG_W];
   assign out_flags    = reset ? '0 : head[FLAG_W-1:0];
   assign sticky_flags = reset ? '0 : sticky_q;
   assign overflow_err = reset ? 1'b0 : overflow_q;

   assign fire    = issue_val & issue_rdy;
   assign pop     = out_valid & out_ready;
   assign push_ok = mul_done & ~fifo_full;

   fp_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (mul_done & ~reset),
      .wr_data ({mul_out, mul_flags}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .occ     (fifo_occ)
   );

   // Credits cover both in-flight and stored results.
   always_ff @(posedge clk) begin
      if (reset) count <= '0;
      else       count <= count + CNT_W'(fire) - CNT_W'(pop);
   end

   // Sticky flags: clear takes effect before the incoming result is ORed in.
   always_ff @(posedge clk) begin
      if (reset) sticky_q <= '0;
      else       sticky_q <= (clear_flags ? '0 : sticky_q) | (push_ok ? mul_flags : '0);
   end

   // Overflow error latches until reset.
   always_ff @(posedge clk) begin
      if (reset)                        overflow_q <= 1'b0;
      else if (mul_done && fifo_full)   overflow_q <= 1'b1;
   end

   // Configuration and occupancy sanity checks.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (DEPTH_OK);
         assert (fifo_occ <= CNT_W'(DEPTH));
         assert (count <= CNT_W'(DEPTH));
      end
   end

endmodule

// File: tb/tb_fp_mul_result_queue.sv
// Directed bench for fp_mul_result_queue with a scoreboard of expected results
// and a behavioural stand-in for the 4-cycle multiplier pipeline.
module tb_fp_mul_result_queue;
   import fp_mul_result_queue_pkg::*;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned SIG_W  = 24;
   localparam int unsigned DATA_W = EXP_W + SIG_W;
   localparam int unsigned DEPTH  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              issue_val;
   logic              issue_rdy;
   logic              mul_done;
   logic [DATA_W-1:0] mul_out;
   logic [FLAG_W-1:0] mul_flags;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [FLAG_W-1:0] out_flags;
   logic [FLAG_W-1:0] sticky_flags;
   logic              clear_flags;
   logic              overflow_err;

   fp_mul_result_queue #(
      .expWidth (EXP_W),
      .sigWidth (SIG_W),
      .DEPTH    (DEPTH),
      .LATENCY  (MUL_LATENCY)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .issue_val    (issue_val),
      .issue_rdy    (issue_rdy),
      .mul_done     (mul_done),
      .mul_out      (mul_out),
      .mul_flags    (mul_flags),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_flags    (out_flags),
      .sticky_flags (sticky_flags),
      .clear_flags  (clear_flags),
      .overflow_err (overflow_err)
   );

   typedef struct packed {
      logic              v;
      logic [DATA_W-1:0] data;
      logic [FLAG_W-1:0] flags;
   } op_t;

   op_t                      pipe [MUL_LATENCY];
   logic [DATA_W+FLAG_W-1:0] sb [$];

   int vectors      = 0;
   int miscompares  = 0;
   int cnt          = 0;
   int fires        = 0;
   int pops         = 0;
   int cyc          = 0;
   int last_pop_cyc = 0;
   int gaps         = 0;
   int rdy_drops    = 0;

   logic [DATA_W-1:0] next_data;
   logic [FLAG_W-1:0] next_flags;
   logic              direct_done;
   logic [DATA_W-1:0] direct_data;
   logic [FLAG_W-1:0] direct_flags;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_mul();
      mul_done  = pipe[MUL_LATENCY-1].v | direct_done;
      mul_out   = pipe[MUL_LATENCY-1].v ? pipe[MUL_LATENCY-1].data  : direct_data;
      mul_flags = pipe[MUL_LATENCY-1].v ? pipe[MUL_LATENCY-1].flags : direct_flags;
   endtask

   // One clock: sample handshakes, score pops, advance the multiplier model.
   task automatic tick();
      logic f;
      logic p;
      logic [DATA_W+FLAG_W-1:0] e;
      drive_mul();
      #1;
      f = issue_val & issue_rdy;
      p = out_valid & out_ready;
      if (!reset) begin
         check("issue_rdy_credit", 64'(issue_rdy), 64'(cnt < int'(DEPTH)));
         if (!issue_rdy) rdy_drops++;
      end
      if (p) begin
         if (pops > 0 && cyc != last_pop_cyc + 1) gaps++;
         pops++;
         last_pop_cyc = cyc;
         check("sb_nonempty_on_pop", 64'(sb.size() != 0), 64'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pop_data", 64'(out_data), 64'(e[DATA_W+FLAG_W-1:FLAG_W]));
            check("pop_flags", 64'(out_flags), 64'(e[FLAG_W-1:0]));
         end
      end
      if (f) begin
         fires++;
         sb.push_back({next_data, next_flags});
      end
      @(posedge clk);
      for (int i = MUL_LATENCY - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '{v: f, data: next_data, flags: next_flags};
      if (f) next_data = next_data + 32'h0103_0507;
      if (reset) begin
         for (int i = 0; i < int'(MUL_LATENCY); i++) pipe[i] = '0;
         sb.delete();
         cnt = 0;
      end else begin
         cnt = cnt + int'(f) - int'(p);
      end
      cyc++;
      @(negedge clk);
      drive_mul();
      #1;
   endtask

   initial begin
      for (int i = 0; i < int'(MUL_LATENCY); i++) pipe[i] = '0;
      reset        = 1'b1;
      issue_val    = 1'b0;
      out_ready    = 1'b0;
      clear_flags  = 1'b0;
      direct_done  = 1'b0;
      direct_data  = '0;
      direct_flags = '0;
      next_data    = 32'h1000_0001;
      next_flags   = '0;
      drive_mul();
      @(negedge clk);
      tick();
      tick();

      // Outputs while reset is held
      check("rst_issue_rdy", 64'(issue_rdy), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_flags", 64'(out_flags), 64'(0));
      check("rst_sticky", 64'(sticky_flags), 64'(0));
      check("rst_overflow", 64'(overflow_err), 64'(0));
      reset = 1'b0;
      #1;
      check("post_rst_issue_rdy", 64'(issue_rdy), 64'(1));

      // Single op: 2.0 * 3.0 = 6.0
      next_data  = 32'h40C0_0000;
      next_flags = '0;
      issue_val  = 1'b1;
      tick();
      issue_val  = 1'b0;
      repeat (3) tick();
      check("single_no_bypass", 64'(out_valid), 64'(0));
      tick();
      check("single_valid", 64'(out_valid), 64'(1));
      check("single_data", 64'(out_data), 64'(32'h40C0_0000));
      check("single_flags", 64'(out_flags), 64'(0));
      check("single_sticky", 64'(sticky_flags), 64'(0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_drained", 64'(out_valid), 64'(0));

      // Backpressure: credits run out after exactly DEPTH fires
      next_data = 32'h2000_0000;
      fires     = 0;
      issue_val = 1'b1;
      for (int i = 0; i < 20 && issue_rdy; i++) tick();
      check("bp_fires", 64'(fires), 64'(DEPTH));
      issue_val = 1'b0;
      repeat (6) tick();
      check("bp_rdy_low", 64'(issue_rdy), 64'(0));
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_no_overflow", 64'(overflow_err), 64'(0));
      issue_val = 1'b1;
      out_ready = 1'b1;
      pops  = 0;
      fires = 0;
      repeat (8) tick();
      check("bp_pops", 64'(pops), 64'(8));
      check("bp_refires", 64'(fires), 64'(7));
      issue_val = 1'b0;
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      check("bp_sb_empty", 64'(sb.size()), 64'(0));
      check("bp_end_valid", 64'(out_valid), 64'(0));

      // Full throughput: 20 back-to-back issues
      pops      = 0;
      fires     = 0;
      gaps      = 0;
      rdy_drops = 0;
      issue_val = 1'b1;
      repeat (20) tick();
      issue_val = 1'b0;
      for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
      check("tp_fires", 64'(fires), 64'(20));
      check("tp_pops", 64'(pops), 64'(20));
      check("tp_gaps", 64'(gaps), 64'(0));
      check("tp_rdy_drops", 64'(rdy_drops), 64'(0));
      out_ready = 1'b0;

      // Sticky flags accumulate and clear
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      check("sticky_cleared", 64'(sticky_flags), 64'(0));
      out_ready  = 1'b1;
      next_flags = pack_flags(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      issue_val  = 1'b1;
      tick();
      next_flags = pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      issue_val  = 1'b0;
      repeat (7) tick();
      check("sticky_or", 64'(sticky_flags), 64'(5'b10101));
      next_flags = pack_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      issue_val  = 1'b1;
      tick();
      issue_val  = 1'b0;
      for (int i = 0; i < 10 && !mul_done; i++) tick();
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      check("sticky_clear_and_push", 64'(sticky_flags), 64'(5'b00001));
      repeat (3) tick();
      check("sticky_sb_empty", 64'(sb.size()), 64'(0));
      next_flags = '0;
      out_ready  = 1'b0;

      // Protocol violation: nine direct pushes into an 8-entry FIFO
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      for (int i = 0; i < 9; i++) begin
         direct_done  = 1'b1;
         direct_data  = 32'hA000_0000 + 32'(i);
         direct_flags = (i == 8) ? pack_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0)
                                 : pack_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         if (i < 8) sb.push_back({direct_data, direct_flags});
         if (i == 8) check("ovf_before_9th", 64'(overflow_err), 64'(0));
         tick();
      end
      direct_done = 1'b0;
      check("ovf_after_9th", 64'(overflow_err), 64'(1));
      check("ovf_sticky_drop", 64'(sticky_flags), 64'(5'b00010));
      repeat (5) tick();
      check("ovf_holds", 64'(overflow_err), 64'(1));
      check("ovf_head_kept", 64'(out_data), 64'(32'hA000_0000));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("ovf_cleared_by_reset", 64'(overflow_err), 64'(0));
      check("ovf_rst_valid", 64'(out_valid), 64'(0));

      // Reset mid-stream: 3 stored, 2 in flight
      out_ready  = 1'b0;
      next_flags = 5'b11111;
      issue_val  = 1'b1;
      repeat (5) tick();
      issue_val  = 1'b0;
      repeat (2) tick();
      check("mid_valid", 64'(out_valid), 64'(1));
      check("mid_sticky", 64'(sticky_flags), 64'(5'b11111));
      reset = 1'b1;
      tick();
      check("mid_rst_issue_rdy", 64'(issue_rdy), 64'(0));
      check("mid_rst_valid", 64'(out_valid), 64'(0));
      check("mid_rst_data", 64'(out_data), 64'(0));
      check("mid_rst_flags", 64'(out_flags), 64'(0));
      check("mid_rst_sticky", 64'(sticky_flags), 64'(0));
      reset = 1'b0;
      #1;
      check("mid_post_rdy", 64'(issue_rdy), 64'(1));
      check("mid_post_valid", 64'(out_valid), 64'(0));
      pops       = 0;
      next_flags = pack_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      out_ready  = 1'b1;
      issue_val  = 1'b1;
      repeat (2) tick();
      issue_val  = 1'b0;
      for (int i = 0; i < 15 && sb.size() != 0; i++) tick();
      check("mid_post_pops", 64'(pops), 64'(2));
      check("mid_post_sticky", 64'(sticky_flags), 64'(5'b00010));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fp_mul_result_queue.md
Name: fp_mul_result_queue

Overview:
Downstream companion to the pipelined floating-point multiplier, which has a fixed 4-cycle val-to-done latency and cannot stall. The block does three things:
- Grants issue slots to the upstream producer using credits, so every in-flight product has a guaranteed buffer slot.
- Captures each product and its exception flags into a FIFO when the multiplier asserts done, and presents them to the consumer over a ready/valid handshake.
- Keeps sticky IEEE exception flags (fflags-style) across all delivered results.

Parameters:
expWidth, 8, exponent field width of the standard-format number
sigWidth, 24, significand width including hidden bit; data width is expWidth+sigWidth
DEPTH, 8, FIFO entries and total credits; must be a power of two and at least LATENCY+2 for full throughput
LATENCY, 4, multiplier val-to-done latency in cycles; informational, used only for assertions

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
issue_val  input  1  upstream requests to start a multiply
issue_rdy  output  1  a credit is available; multiplier val must equal issue_val & issue_rdy
mul_done  input  1  multiplier done strobe
mul_out  input  expWidth+sigWidth  multiplier result, valid when mul_done=1
mul_flags  input  5  multiplier exceptionFlags {invalid, infinite, overflow, underflow, inexact}
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_data  output  expWidth+sigWidth  head result
out_flags  output  5  head result flags
sticky_flags  output  5  OR of flags of every result pushed since reset or the last clear
clear_flags  input  1  clear sticky_flags
overflow_err  output  1  sticky error: mul_done arrived while the FIFO was full

Behaviour:
- Reset is synchronous. While reset=1 every output is 0: issue_rdy=0, out_valid=0, out_data=0, out_flags=0, sticky_flags=0, overflow_err=0. Credit count, pointers and FIFO occupancy are also cleared.
- issue_rdy=1 from the first cycle after reset deasserts.
- Resetting mid-operation discards all in-flight and queued results. Any mul_done in the reset cycle is ignored.
- Definitions: fire = issue_val & issue_rdy; push = mul_done; pop = out_valid & out_ready.
- Credit counter: a width of $clog2(DEPTH)+1 bits counts in-flight plus stored results.
  - count_next = count + fire - pop.
  - issue_rdy = (count < DEPTH), registered-free combinational from count.
  - Simultaneous fire and pop leaves count unchanged.
- FIFO: circular buffer of DEPTH entries, each {data, flags}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked separately; full = (occ == DEPTH), empty = (occ == 0).
- Push writes at the write pointer. out_valid, out_data and out_flags are driven from the head entry.
  - Latency from mul_done to out_valid is 1 cycle: an entry written at edge N is visible after edge N.
  - There is no bypass of an empty FIFO.
- Push and pop in the same cycle, with the FIFO non-empty and not full: occupancy is unchanged and both pointers advance.
- Push while full cannot happen if credits are honoured. If it does: the data is dropped, overflow_err is set and holds until reset, and pointers are unchanged.
- out_data and out_flags hold stable while out_valid=1 and out_ready=0.
- Sticky flags: sticky_next = (clear_flags ? 0 : sticky) | (push ? mul_flags : 0).
  - Clear and push in the same cycle leaves only the pushed flags.
  - Flags dropped on overflow are not ORed in.
- Throughput: with out_ready held at 1 and DEPTH >= LATENCY+2, issue_rdy stays 1 and one result is delivered per cycle.

Decomposition:
- Shared float package:
  - FLAG_* bit index constants (INVALID=4, INFINITE=3, OVERFLOW=2, UNDERFLOW=1, INEXACT=0)
  - a typedef for the 5-bit flag vector
  - the multiplier latency constant MUL_LATENCY=4, shared with the multiplier wrapper
- One natural sub-module: fp_sync_fifo, a parameterised width/depth circular FIFO with full, empty and occupancy.
- The credit counter and sticky flag logic stay in the top level.

Test Plan:
- Single op, expWidth=8, sigWidth=24. Issue 2.0 (0x40000000) × 3.0 (0x40400000) with the multiplier attached, issue at cycle 0 → mul_done at cycle 4, out_valid=1 at cycle 5, out_data=0x40C00000, out_flags=0, sticky_flags=0.
- Backpressure, DEPTH=8, out_ready=0, issue_val held at 1 → issue_rdy drops after exactly 8 fires. 8 entries are stored with no overflow_err. Raising out_ready drains 8 in order and one fire is re-enabled per pop.
- Full throughput, out_ready=1, 20 back-to-back issues → issue_rdy never drops. 20 results delivered on consecutive cycles, in issue order.
- Sticky flags: push a result with mul_flags=5'b00101, then one with 5'b10000 → sticky_flags=5'b10101. Assert clear_flags in the same cycle as a push with 5'b00001 → sticky_flags=5'b00001.
- Protocol violation: drive mul_done directly 9 times with out_ready=0 → the 9th is dropped, overflow_err=1 and stays 1 until reset.
- Reset mid-stream: 3 results queued and 2 in flight, assert reset for 1 cycle → all outputs 0 and later mul_done pulses are stored normally. Sticky flags reflect only post-reset results.
